// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle Y86 stage controller:
// stage states, status codes, icode constants and the per-stage control bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } stage_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic wb;
        logic pc;
        logic mem_req;
        logic busy;
    } ctrl_t;

    // Control outputs implied by a stage state.
    function automatic ctrl_t stage_ctrl(stage_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.fetch = 1'b1;
                c.busy  = 1'b1;
            end
            ST_DECODE: begin
                c.decode = 1'b1;
                c.busy   = 1'b1;
            end
            ST_EXECUTE: begin
                c.execute = 1'b1;
                c.busy    = 1'b1;
            end
            ST_MEMORY: begin
                c.mem_req = 1'b1;
                c.busy    = 1'b1;
            end
            ST_WRITEBACK: begin
                c.wb   = 1'b1;
                c.busy = 1'b1;
            end
            ST_PCUPD: begin
                c.pc   = 1'b1;
                c.busy = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instructions that actually touch data memory.
    function automatic logic is_mem_icode(logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) ||
               (ic == I_CALL)   || (ic == I_RET)    ||
               (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/cpu_stage_timer.sv
// MEMORY-stage wait timer: cleared by load, advances while counting,
// expire marks the LIMIT-th consecutive counted cycle.
module cpu_stage_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    // Cycle counter; stops at LAST so it never wraps while waiting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && !expire_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle Y86 stage sequencer with run/step control and memory timeout.
// Optional: define CPU_STAGE_CTRL_SKIP_MEM_EN to bypass MEMORY for non-memory icodes.
module cpu_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             dmem_error_i,
    input  logic             mem_ack_i,
    output logic             fetch_en_o,
    output logic             decode_en_o,
    output logic             execute_en_o,
    output logic             wb_en_o,
    output logic             pc_en_o,
    output logic             mem_req_o,
    output logic [2:0]       stat_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [CNT_W-1:0] RET_MAX = '1;

    stage_e           state_q;
    stage_e           state_n;
    stat_e            stat_q;
    stat_e            stat_n;
    logic             step_q;
    logic             step_n;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] retired_q;
    logic             tmo_expire;

    cpu_stage_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (state_q == ST_EXECUTE),
        .count_i  (state_q == ST_MEMORY),
        .expire_o (tmo_expire)
    );

    // Next stage, halt cause and single-step latch.
    always_comb begin
        state_n = state_q;
        stat_n  = stat_q;
        step_n  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i || step_i) begin
                    state_n = ST_FETCH;
                    step_n  = step_i;
                end
            end
            ST_FETCH: begin
                if (imem_error_i) begin
                    state_n = ST_HALT;
                    stat_n  = STAT_ADR;
                end else if (!instr_valid_i) begin
                    state_n = ST_HALT;
                    stat_n  = STAT_INS;
                end else if (icode_i == I_HALT) begin
                    state_n = ST_HALT;
                    stat_n  = STAT_HLT;
                end else begin
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_n = ST_EXECUTE;
            end
            ST_EXECUTE: begin
`ifdef CPU_STAGE_CTRL_SKIP_MEM_EN
                state_n = is_mem_icode(icode_i) ? ST_MEMORY : ST_WRITEBACK;
`else
                state_n = ST_MEMORY;
`endif
            end
            ST_MEMORY: begin
                if (mem_ack_i) begin
                    if (dmem_error_i) begin
                        state_n = ST_HALT;
                        stat_n  = STAT_ADR;
                    end else begin
                        state_n = ST_WRITEBACK;
                    end
                end else if (tmo_expire) begin
                    state_n = ST_HALT;
                    stat_n  = STAT_ADR;
                end
            end
            ST_WRITEBACK: begin
                state_n = ST_PCUPD;
            end
            ST_PCUPD: begin
                if (run_i && !step_q) begin
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                    step_n  = 1'b0;
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, status, step latch and registered stage controls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            stat_q  <= STAT_AOK;
            step_q  <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_n;
            stat_q  <= stat_n;
            step_q  <= step_n;
            ctrl_q  <= stage_ctrl(state_n);
        end
    end

    // Retired count bumps as PCUPD completes and sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retired_q <= '0;
        end else if (state_q == ST_PCUPD && retired_q != RET_MAX) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign fetch_en_o   = ctrl_q.fetch;
    assign decode_en_o  = ctrl_q.decode;
    assign execute_en_o = ctrl_q.execute;
    assign wb_en_o      = ctrl_q.wb;
    assign pc_en_o      = ctrl_q.pc;
    assign mem_req_o    = ctrl_q.mem_req;
    assign busy_o       = ctrl_q.busy;
    assign stat_o       = stat_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Bench for cpu_stage_ctrl: instruction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cpu_stage_ctrl;

    localparam int CNT_W   = 4;
    localparam int TMO     = 8;
    localparam int RET_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [3:0]       icode = 4'h6;
    logic             valid = 1'b1;
    logic             ierr = 1'b0;
    logic             derr = 1'b0;
    logic             ack = 1'b0;
    logic             f_en, d_en, e_en, w_en, p_en, mreq, busy;
    logic [2:0]       stat;
    logic [CNT_W-1:0] ret;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  checking = 1'b0;

    cpu_stage_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .run_i         (run),
        .step_i        (step),
        .icode_i       (icode),
        .instr_valid_i (valid),
        .imem_error_i  (ierr),
        .dmem_error_i  (derr),
        .mem_ack_i     (ack),
        .fetch_en_o    (f_en),
        .decode_en_o   (d_en),
        .execute_en_o  (e_en),
        .wb_en_o       (w_en),
        .pc_en_o       (p_en),
        .mem_req_o     (mreq),
        .stat_o        (stat),
        .busy_o        (busy),
        .retired_o     (ret)
    );

    always #5 clk = ~clk;

    // Reference model: k = cycles since FETCH of the current instruction,
    // mw = number of MEMORY cycles once the memory access has resolved.
    bit m_act, m_halt, m_step, m_known;
    int m_k, m_mw, m_stat, m_ret;

    function automatic bit memop(input logic [3:0] ic);
        return ic == 4 || ic == 5 || ic == 8 || ic == 9 || ic == 10 || ic == 11;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_halt = 0; m_step = 0; m_known = 0;
            m_k = 0; m_mw = 0; m_stat = 1; m_ret = 0;
        end else if (m_halt) begin
            m_act = 0;
        end else if (!m_act) begin
            if (run || step) begin
                m_act = 1; m_k = 0; m_known = 0; m_step = step;
            end
        end else if (m_k == 0) begin
            if (ierr) begin m_halt = 1; m_act = 0; m_stat = 3; end
            else if (!valid) begin m_halt = 1; m_act = 0; m_stat = 4; end
            else if (icode == 0) begin m_halt = 1; m_act = 0; m_stat = 2; end
            else m_k = 1;
`ifdef CPU_STAGE_CTRL_SKIP_MEM_EN
        end else if (m_k == 2 && !memop(icode)) begin
            m_known = 1; m_mw = 0; m_k = 3;
`endif
        end else if (m_k >= 3 && !m_known) begin
            if (ack) begin
                if (derr) begin m_halt = 1; m_act = 0; m_stat = 3; end
                else begin m_known = 1; m_mw = m_k - 2; m_k++; end
            end else if (m_k - 2 == TMO) begin
                m_halt = 1; m_act = 0; m_stat = 3;
            end else m_k++;
        end else if (m_known && m_k == 4 + m_mw) begin
            m_ret = (m_ret + 1 > RET_MAX) ? RET_MAX : m_ret + 1;
            if (run && !m_step) begin m_k = 0; m_known = 0; end
            else begin m_act = 0; m_step = 0; end
        end else begin
            m_k++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [13:0] exp_v, act_v;
        if (checking && rst_n) begin
            exp_v = {m_act && m_k == 0, m_act && m_k == 1, m_act && m_k == 2,
                     m_act && m_k >= 3 && !m_known,
                     m_act && m_known && m_k == 3 + m_mw,
                     m_act && m_known && m_k == 4 + m_mw,
                     m_act, 3'(m_stat), 4'(m_ret)};
            act_v = {f_en, d_en, e_en, mreq, w_en, p_en, busy, stat, ret};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 0; step = 0; icode = 4'h6; valid = 1; ierr = 0; derr = 0; ack = 0;
        #1;
        chk("reset_enables", {f_en, d_en, e_en, w_en, p_en}, 0);
        chk("reset_memreq_busy", {mreq, busy}, 0);
        chk("reset_stat", stat, 1);
        chk("reset_retired", ret, 0);
        tick(2);
        rst_n = 1'b1;
        checking = 1'b1;
    endtask

    initial begin
        logic [5:0] sweep [6];
        int cnt;
        sweep[0] = 6'b100000; sweep[1] = 6'b010000; sweep[2] = 6'b001000;
        sweep[3] = 6'b000100; sweep[4] = 6'b000010; sweep[5] = 6'b000001;
        #2;

        // Free run with immediate ack: ordered sweep, 6 cycles each.
        do_reset();
        run = 1; ack = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("sweep_%0d", i), {f_en, d_en, e_en, mreq, w_en, p_en}, sweep[i]);
        end
        tick(1);
        chk("run_retired_1", ret, 1);
        chk("run_refetch", f_en, 1);
        tick(6);
        chk("run_retired_2", ret, 2);
        run = 0;
        tick(6);
        chk("run_drop_retired", ret, 3);
        chk("run_drop_idle", busy, 0);
        tick(3);
        chk("run_drop_stays", {busy, ret}, 3);

        // Single step; a second step pulse mid-instruction is ignored.
        do_reset();
        ack = 1; step = 1;
        tick(1);
        step = 0;
        tick(2);
        step = 1;
        tick(1);
        step = 0;
        tick(3);
        chk("step_retired", ret, 1);
        chk("step_idle", busy, 0);
        tick(5);
        chk("step_no_more", {busy, ret}, 1);

        // Halt icode: terminal despite run held high.
        do_reset();
        run = 1; icode = 4'h0;
        tick(2);
        chk("halt_stat", stat, 2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            cnt += int'(f_en) + int'(d_en) + int'(e_en) + int'(w_en) + int'(p_en);
        end
        chk("halt_no_enables", cnt, 0);
        chk("halt_stat_hold", stat, 2);

        // Memory timeout.
        do_reset();
        run = 1; ack = 0;
        tick(3);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            cnt += int'(mreq);
        end
        chk("tmo_mem_cycles", cnt, 8);
        chk("tmo_stat", stat, 3);
        chk("tmo_memreq", mreq, 0);

        // Fetch error priority and invalid instruction.
        do_reset();
        run = 1; valid = 0; ierr = 1;
        tick(2);
        chk("adr_priority", stat, 3);
        do_reset();
        run = 1; valid = 0;
        tick(2);
        chk("ins_stat", stat, 4);

        // Data-memory error on ack.
        do_reset();
        run = 1; icode = 4'h5; ack = 1; derr = 1;
        tick(5);
        chk("dmem_err_stat", stat, 3);
        chk("dmem_err_retired", ret, 0);

        // Late ack after three MEMORY cycles.
        do_reset();
        run = 1; ack = 0;
        tick(6);
        ack = 1;
        tick(1);
        ack = 0; run = 0;
        tick(2);
        chk("late_ack_retired", ret, 1);
        chk("late_ack_idle", busy, 0);

        // Reset mid-MEMORY, then retired-count saturation.
        do_reset();
        run = 1; ack = 1;
        tick(7);
        chk("pre_rst_retired", ret, 1);
        ack = 0;
        tick(4);
        chk("pre_rst_memreq", mreq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmem_rst_memreq", mreq, 0);
        chk("midmem_rst_busy", busy, 0);
        chk("midmem_rst_retired", ret, 0);
        chk("midmem_rst_stat", stat, 1);
        do_reset();
        run = 1; ack = 1;
        tick(17 * 6 + 1);
        chk("sat_retired", ret, 15);
        tick(6);
        chk("sat_hold", ret, 15);
        run = 0;
        tick(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
